// File: rtl/dac_seq_ctrl_if.sv
// Sequencer-side bus of the DAC update sequencer: sample words and control in,
// status and DAC pin drive out. The sequencer takes the slave view.
interface dac_seq_ctrl_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 12
);
  logic [NCH*DATA_W-1:0] data_flat;
  logic [NCH-1:0]        ch_mask;
  logic                  sync_mode;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  spi_sck;
  logic                  spi_mosi;
  logic                  dac_cs;
  logic                  dac_clr;

  modport master (
    output data_flat, ch_mask, sync_mode, start,
    input  busy, done, spi_sck, spi_mosi, dac_cs, dac_clr
  );

  modport slave (
    input  data_flat, ch_mask, sync_mode, start,
    output busy, done, spi_sck, spi_mosi, dac_cs, dac_clr
  );
endinterface

// File: rtl/dac_seq_ctrl.sv
// Multi-channel DAC update sequencer with a built-in 32-bit SPI (mode 0)
// serializer. One start snapshots all channel words and sends one frame per
// masked channel in ascending order. Sync mode defers the DAC update to the
// last frame. SPI/status outputs come straight from flops; they lag the FSM
// state by one cycle.
module dac_seq_ctrl #(
  parameter int NCH     = 4,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 2,
  parameter int CLR_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  dac_seq_ctrl_if.slave  bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(CLR_CYC + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_SHIFT, S_HOLD, S_GAP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         clr_cnt_q;
  logic [DW-1:0]         div_q;
  logic                  phase_q;     // 0 = SCK low half, 1 = SCK high half
  logic [4:0]            bit_q;
  logic [NCH*DATA_W-1:0] data_q;
  logic [NCH-1:0]        pend_q;
  logic                  sync_q;
  logic [31:0]           frame_q;

  logic sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d;
  logic clr_q, clr_d, busy_q, busy_d, done_q, done_d;

  logic              div_end;
  logic [3:0]        sel_ch;
  logic [DATA_W-1:0] sel_dat;
  logic [NCH-1:0]    sel_oh;
  logic              last_frame;
  logic [3:0]        cmd;
  logic [15:0]       word16;
  logic [31:0]       frame_nxt;

  assign div_end = (div_q == DIV_LAST);

  // Pick the lowest pending channel and build its frame word.
  always_comb begin
    sel_ch  = '0;
    sel_dat = '0;
    sel_oh  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_ch     = 4'(i);
        sel_dat    = data_q[i*DATA_W +: DATA_W];
        sel_oh     = '0;
        sel_oh[i]  = 1'b1;
      end
    end
    last_frame = ((pend_q & ~sel_oh) == '0);
    // Sync mode: write-only frames, final frame writes and updates all outputs.
    cmd        = sync_q ? (last_frame ? 4'b0010 : 4'b0000) : 4'b0011;
    word16     = 16'(sel_dat) << (16 - DATA_W);
    frame_nxt  = {8'h00, cmd, sel_ch, word16};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (clr_cnt_q == CLR_LAST) state_d = S_IDLE;
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = (pend_q == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (div_end && phase_q && bit_q == 5'd0) state_d = S_HOLD;
      S_HOLD:  if (div_end) state_d = S_GAP;
      // Going straight to DONE after the last gap saves the idle LOAD cycle.
      S_GAP:   if (div_end) state_d = (pend_q == '0) ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Counters, input snapshot and frame shift bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_q <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      bit_q     <= 5'd31;
      data_q    <= '0;
      pend_q    <= '0;
      sync_q    <= 1'b0;
      frame_q   <= '0;
    end else begin
      if (state_q == S_INIT) clr_cnt_q <= clr_cnt_q + 1'b1;

      if (state_q == S_SHIFT || state_q == S_HOLD || state_q == S_GAP)
        div_q <= div_end ? '0 : div_q + 1'b1;
      else
        div_q <= '0;

      if (state_q == S_SHIFT) begin
        if (div_end) begin
          phase_q <= ~phase_q;
          if (phase_q && bit_q != 5'd0) bit_q <= bit_q - 5'd1;
        end
      end else begin
        phase_q <= 1'b0;
      end

      if (state_q == S_LOAD) bit_q <= 5'd31;

      if (state_q == S_IDLE && bus.start) begin
        data_q <= bus.data_flat;
        pend_q <= bus.ch_mask;
        sync_q <= bus.sync_mode;
      end

      if (state_q == S_LOAD && pend_q != '0) begin
        pend_q  <= pend_q & ~sel_oh;
        frame_q <= frame_nxt;
      end
    end
  end

  // Output next values. busy/dac_clr follow the next state so they move on
  // the accepting / INIT-exit edge; the SPI pins follow the current state.
  always_comb begin
    sck_d  = (state_q == S_SHIFT) && phase_q;
    cs_d   = !(state_q == S_SHIFT || state_q == S_HOLD);
    mosi_d = (state_q == S_SHIFT || state_q == S_HOLD) ? frame_q[bit_q] : 1'b0;
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE);
    clr_d  = (state_d != S_INIT);
  end

  // Output registers; reset forces the pins safe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      cs_q   <= 1'b1;
      clr_q  <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      cs_q   <= cs_d;
      clr_q  <= clr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.dac_cs   = cs_q;
  assign bus.dac_clr  = clr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Randomized bench for dac_seq_ctrl: a frame-list model built from the
// command/addressing rules, checked against an SPI pin monitor.
module tb_dac_seq_ctrl;
  localparam int NCH = 4, DW = 12, CD = 2, CLR = 16;
  localparam int DWF = NCH * DW;
  localparam int FP  = 66 * CD + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dac_seq_ctrl_if #(.NCH(NCH), .DATA_W(DW)) bus();

  dac_seq_ctrl #(.NCH(NCH), .DATA_W(DW), .CLK_DIV(CD), .CLR_CYC(CLR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, errors = 0, cyc = 0;

  // pin monitor state
  logic        sck_p = 1'b0, cs_p = 1'b1;
  logic [31:0] sh = '0;
  int          bitc = 0, lowc = 0, sck_rise_cnt = 0, cs_fall_cnt = 0;
  logic [31:0] frm_q[$];
  int          bits_q[$], low_q[$], fall_q[$], done_q[$];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (!bus.dac_cs && cs_p) begin
      fall_q.push_back(cyc);
      cs_fall_cnt++;
      lowc = 0; bitc = 0; sh = '0;
    end
    if (bus.spi_sck && !sck_p) begin
      sh = {sh[30:0], bus.spi_mosi};
      bitc++;
      sck_rise_cnt++;
    end
    if (!bus.dac_cs) lowc++;
    if (bus.dac_cs && !cs_p) begin
      frm_q.push_back(sh);
      bits_q.push_back(bitc);
      low_q.push_back(lowc);
    end
    if (bus.done) done_q.push_back(cyc);
    sck_p = bus.spi_sck;
    cs_p  = bus.dac_cs;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DWF-1:0] rnd_data();
    return DWF'({$urandom(), $urandom()});
  endfunction

  // Release reset and time the dac_clr / busy release.
  task automatic wait_clr(input bit pulse_start);
    int fc, fb, f0;
    fc = -1; fb = -1; f0 = cs_fall_cnt;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= CLR + 4; j++) begin
      @(negedge clk);
      if (pulse_start) bus.start = (j == 5);
      if (fc < 0 && bus.dac_clr) fc = j;
      if (fb < 0 && !bus.busy) fb = j;
    end
    bus.start = 1'b0;
    chk("clr_len", fc, CLR);
    chk("busy_init", fb, CLR);
    chk("init_no_cs", cs_fall_cnt - f0, 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("idle", bus.busy, 0);
  endtask

  task automatic run_seq(input logic [NCH-1:0] mask, input logic [DWF-1:0] data,
                         input logic sync, input bit perturb);
    logic [31:0] exp_q[$];
    int m, last, k, t, fb, db, sb, exp_done;
    m = 0; last = -1;
    for (int n = 0; n < NCH; n++) if (mask[n]) begin m++; last = n; end
    for (int n = 0; n < NCH; n++) begin
      if (mask[n]) begin
        logic [3:0] c;
        c = sync ? ((n == last) ? 4'h2 : 4'h0) : 4'h3;
        exp_q.push_back({8'h00, c, 4'(n), data[n*DW +: DW], 4'h0});
      end
    end
    wait_idle();
    fb = frm_q.size(); db = done_q.size(); sb = sck_rise_cnt;
    bus.data_flat = data; bus.ch_mask = mask; bus.sync_mode = sync;
    bus.start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (done_q.size() == db && t < m * FP + 20) begin
      @(negedge clk);
      t++;
      if (perturb) begin
        if (t == 40) begin
          bus.data_flat = rnd_data();
          bus.ch_mask   = ~mask;
          bus.start     = 1'b1;
        end else if (t == 41) begin
          bus.start = 1'b0;
        end
      end
    end
    exp_done = (m == 0) ? k + 2 : k + m * FP + 1;
    chk("done_time", (done_q.size() > db) ? done_q[db] : -1, exp_done);
    repeat (6) @(negedge clk);
    chk("done_cnt", done_q.size() - db, 1);
    chk("busy_after", bus.busy, 0);
    chk("frames", frm_q.size() - fb, m);
    chk("sck_rises", sck_rise_cnt - sb, 32 * m);
    for (int i = 0; i < m && fb + i < frm_q.size(); i++) begin
      chk("frame", frm_q[fb+i], exp_q[i]);
      chk("bits", bits_q[fb+i], 32);
      chk("cs_low", low_q[fb+i], 65 * CD);
      chk("cs_fall", fall_q[fb+i], k + 2 + i * FP);
    end
  endtask

  initial begin
    int t, sb;
    bus.start = 1'b0; bus.data_flat = '0; bus.ch_mask = '0; bus.sync_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", {bus.dac_cs, bus.spi_sck, bus.spi_mosi, bus.dac_clr, bus.busy, bus.done},
        6'b100010);
    wait_clr(1'b1);

    run_seq(4'b0001, {36'h0, 12'hABC}, 1'b0, 1'b0);
    run_seq(4'b1011, {12'hFFF, 12'h000, 12'h456, 12'h123}, 1'b1, 1'b0);
    run_seq(4'b0000, rnd_data(), 1'($urandom_range(0, 1)), 1'b0);
    run_seq(4'b0110, rnd_data(), 1'($urandom_range(0, 1)), 1'b1);
    repeat (8) run_seq(4'($urandom_range(0, 15)), rnd_data(), 1'($urandom_range(0, 1)), 1'b0);

    // reset during bit 10 of a frame
    wait_idle();
    sb = sck_rise_cnt;
    bus.data_flat = rnd_data(); bus.ch_mask = 4'b0100; bus.sync_mode = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (sck_rise_cnt - sb < 22 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reach", sck_rise_cnt - sb, 22);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out", {bus.dac_cs, bus.spi_sck, bus.spi_mosi, bus.dac_clr, bus.busy, bus.done},
        6'b100010);
    repeat (3) @(negedge clk);
    wait_clr(1'b0);
    run_seq(4'b0101, rnd_data(), 1'b1, 1'b0);
    run_seq(4'($urandom_range(1, 15)), rnd_data(), 1'($urandom_range(0, 1)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_seq_ctrl.md
# dac_seq_ctrl

Multi-channel DAC update sequencer with built-in SPI serializer for a 4-bit-command / 4-bit-address quad DAC (32-bit frames, MSB first). On one `start` it snapshots up to NCH channel words and sends one frame per enabled channel, in ascending channel order. Two modes are supported:
- Independent: each channel is written and updated on its own frame.
- Synchronous: all channels are written first, and every DAC output updates together on the last frame.

It sits between the sample-generation logic and the DAC pins, replacing the single-channel fixed-command FSM.

## Interface
Parameters:
- `NCH`, 4: number of channels, 1..16; channel index is the DAC address.
- `DATA_W`, 12: sample width, 8..16.
- `CLK_DIV`, 2: SCK half-period in clk cycles, ≥1.
- `CLR_CYC`, 16: clk cycles `dac_clr` is held low after reset release, ≥1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `data_flat`, in, NCH*DATA_W: channel n occupies `[n*DATA_W +: DATA_W]`.
- `ch_mask`, in, NCH: bit n set means send channel n.
- `sync_mode`, in, 1: 0 = independent, 1 = synchronous update.
- `start`, in, 1: request a sequence; sampled only in IDLE.
- `busy`, out, 1: high from acceptance (and during INIT) until DONE.
- `done`, out, 1: one-cycle pulse when a sequence ends.
- `spi_sck`, out, 1: SPI clock, idle low.
- `spi_mosi`, out, 1: serial data.
- `dac_cs`, out, 1: chip select, active low.
- `dac_clr`, out, 1: DAC clear, active low.

## Operation
- **Reset values:** `spi_sck`=0, `spi_mosi`=0, `dac_cs`=1, `dac_clr`=0, `busy`=1, `done`=0. State is INIT.
- **States:** INIT → IDLE → LOAD → SHIFT → HOLD → GAP → (LOAD | DONE) → IDLE.
- **INIT:**
  - `dac_clr` stays low for exactly CLR_CYC cycles after `rst` falls.
  - Then `dac_clr`=1, `busy`=0, and the FSM moves to IDLE.
  - `start` is ignored during INIT.
- **IDLE:** when `start`=1, the block captures `data_flat`, `ch_mask` and `sync_mode` into registers and sets `busy`=1. Input changes after capture have no effect.
- **LOAD:**
  - Selects the lowest pending masked channel n and clears its pending bit.
  - Builds the frame word: {8'h00, cmd, n[3:0], data_n, (16-DATA_W) zero bits}.
  - If no channel is pending (including mask = 0), the FSM goes to DONE.
- **Command selection:**
  - `sync_mode`=0: every frame uses cmd 4'b0011 (write and update n).
  - `sync_mode`=1: every frame except the last uses 4'b0000 (write input register n). The last frame uses 4'b0010 (write n, update all).
  - A single channel in sync mode uses 4'b0010.
- **SHIFT (32 bits, bit 31 first):**
  - Each bit has a low phase of CLK_DIV cycles (`spi_sck`=0) followed by a high phase of CLK_DIV cycles (`spi_sck`=1).
  - `spi_mosi` changes only at the start of a low phase. The DAC samples on the rising SCK edge (SPI mode 0).
  - `dac_cs` goes low at the start of the bit-31 low phase.
- **HOLD:** CLK_DIV cycles with `dac_cs`=0, `spi_sck`=0.
- **GAP:** CLK_DIV cycles with `dac_cs`=1, `spi_sck`=0 and `spi_mosi`=0, then back to LOAD.
- **DONE:** `done`=1 for one cycle, `busy`=0 in the same cycle, then IDLE. `start` may be accepted on the following cycle.
- **Reset mid-operation:** all outputs return to their reset values immediately (`dac_cs` high, `spi_sck` low). The partial frame is discarded and the INIT clear sequence reruns.

## Timing
- **Start latency:** `start` is sampled at edge k. LOAD runs in cycle k+1. `dac_cs` falls at edge k+2.
- **Per frame:**
  - `dac_cs` is low for 65*CLK_DIV cycles.
  - Frame-to-frame `dac_cs` period is 66*CLK_DIV + 1 cycles (1 cycle for LOAD).
  - Exactly 32 rising SCK edges occur per frame.
- **Sequence length:** with m masked channels, `done` comes m*(66*CLK_DIV+1)+1 cycles after acceptance. With m=0, `done` comes at k+2.
- **Outputs:** all SPI outputs are driven straight from registers, with no combinational path from inputs.

## Test plan
- **Power-up:** release `rst` → `dac_clr`=0 for exactly 16 cycles, then 1. `busy` falls on the same edge. A `start` pulsed during INIT produces no `dac_cs` activity.
- **Single channel, independent:** NCH=4, DATA_W=12, CLK_DIV=2, mask=4'b0001, ch0=12'hABC, sync=0 → one frame; sampling `spi_mosi` on SCK rising edges gives 32'h0030ABC0. `dac_cs` is low 130 cycles, and `done` comes 134 cycles after acceptance.
- **Synchronous mode:** mask=4'b1011, ch0=12'h123, ch1=12'h456, ch3=12'hFFF, sync=1 → frames 32'h00001230, 32'h00014560, 32'h0023FFF0, in that order. Exactly 3 `dac_cs` pulses, then `done`.
- **Empty mask:** mask=0, `start` → no SCK or `dac_cs` activity; `done` pulses at edge k+2.
- **Input stability:** change `data_flat` and `ch_mask`, and pulse `start`, during frame 1 of a 2-channel sequence → frame words are unchanged, there is no extra sequence, and only one `done` occurs.
- **Reset mid-frame:** assert `rst` during bit 10 of a frame → `dac_cs`=1, `spi_sck`=0, `spi_mosi`=0 immediately. After release, the 16-cycle `dac_clr` sequence repeats and the next `start` works normally.
